// File: rtl/riscv_structures_pkg.sv
// Shared fetch-path types and constants for the instruction fetch unit.
package riscv_structures;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// fetch_queue: small synchronous FIFO of fetched {pc, instr} packets; flush beats push/pop.
module fetch_queue
  import riscv_structures::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_pkt_t din,
  output logic       full,
  output logic       empty,
  output fetch_pkt_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_pkt_t     mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC ownership, imem request, fetch queue, redirect and EBREAK halt.
// Optional trace output enabled by defining IFETCH_TRACE_EN.
module instr_fetch_unit
  import riscv_structures::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic [31:0] fetch_cnt
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [31:0]  pc_q;
  logic [31:0]  fetch_cnt_q;
  logic         q_full;
  logic         q_empty;
  fetch_pkt_t   q_head;
  fetch_pkt_t   q_din;
  logic         pop;
  logic         fetch;

  assign pop   = out_valid && out_ready;
  assign fetch = (state_q == RUN) && (!q_full || pop) && !redirect_valid;
  assign q_din = '{pc: pc_q, instr: imem_rdata};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (q_din),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        BOOT:    state_d = RUN;
        RUN:     if (fetch && imem_rdata == INSTR_EBREAK) state_d = HALT;
        HALT:    state_d = HALT;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      fetch_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        pc_q <= align_word(redirect_pc);
      end else if (fetch) begin
        pc_q        <= pc_q + 32'd4;
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
    end
  end

  // Head fields read as zero while the queue is empty so stale payload never leaks out.
  assign imem_addr = pc_q;
  assign out_valid = !q_empty;
  assign out_instr = q_empty ? 32'h0 : q_head.instr;
  assign out_pc    = q_empty ? 32'h0 : q_head.pc;
  assign halted    = (state_q == HALT);
  assign fetch_cnt = fetch_cnt_q;

`ifdef IFETCH_TRACE_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (fetch)
        $display("%0t ifetch push pc=%h instr=%h", $time, pc_q, imem_rdata);
      if (redirect_valid)
        $display("%0t ifetch redirect pc=%h", $time, align_word(redirect_pc));
      if (state_q == RUN && state_d == HALT)
        $display("%0t ifetch halt pc=%h", $time, pc_q);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected {pc, instr} deliveries.
module tb_instr_fetch_unit;
  import riscv_structures::*;

  localparam logic [31:0] EBREAK_W = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ebreak_en = 1'b0;

  logic [31:0] imem_addr1, imem_rdata1, out_instr1, out_pc1, fetch_cnt1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid1, halted1;
  logic        out_ready = 1'b1;

  logic [31:0] imem_addr2, imem_rdata2, out_instr2, out_pc2, fetch_cnt2;
  logic        out_valid2, halted2;

  int total = 0;
  int bad   = 0;
  int cyc;
  fetch_pkt_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) * 32'h80) + 32'h13;
  endfunction

  assign imem_rdata1 = (ebreak_en && imem_addr1 == 32'h8) ? EBREAK_W : mem_word(imem_addr1);
  assign imem_rdata2 = mem_word(imem_addr2);

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr1),
    .imem_rdata     (imem_rdata1),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid1),
    .out_ready      (out_ready),
    .out_instr      (out_instr1),
    .out_pc         (out_pc1),
    .halted         (halted1),
    .fetch_cnt      (fetch_cnt1)
  );

  instr_fetch_unit #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr2),
    .imem_rdata     (imem_rdata2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .out_valid      (out_valid2),
    .out_ready      (1'b1),
    .out_instr      (out_instr2),
    .out_pc         (out_pc2),
    .halted         (halted2),
    .fetch_cnt      (fetch_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
    fetch_pkt_t p;
    p.pc    = pc;
    p.instr = instr;
    sb.push_back(p);
  endtask

  // Samples at the current negedge, then each following negedge, until n handshakes are seen.
  task automatic expect_out(input int n, input bit use_wrap, output int cycles);
    fetch_pkt_t e;
    int got;
    got    = 0;
    cycles = 0;
    while (got < n && cycles < 20) begin
      if (use_wrap ? out_valid2 : (out_valid1 && out_ready)) begin
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
        check(use_wrap ? "wrap_pc" : "out_pc", use_wrap ? out_pc2 : out_pc1, e.pc);
        check(use_wrap ? "wrap_instr" : "out_instr", use_wrap ? out_instr2 : out_instr1, e.instr);
        got++;
      end
      if (got < n) begin
        @(negedge clk);
        cycles++;
      end
    end
    check("handshake_count", got, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid1, 0);
    check("rst_out_instr", out_instr1, 0);
    check("rst_out_pc", out_pc1, 0);
    check("rst_halted", halted1, 0);
    check("rst_fetch_cnt", fetch_cnt1, 0);
    check("rst_imem_addr", imem_addr1, 32'h0);
    check("rst_wrap_addr", imem_addr2, 32'hFFFF_FFF8);
    rst = 1'b0;

    // Test 1: BOOT cycle then streaming fetch
    @(negedge clk);
    check("boot_out_valid", out_valid1, 0);
    check("boot_imem_addr", imem_addr1, 32'h0);
    push_exp(32'h0, 32'h13);
    push_exp(32'h4, 32'h93);
    push_exp(32'h8, 32'h113);
    expect_out(3, 1'b0, cyc);
    check("t1_latency", cyc, 3);
    check("t1_fetch_cnt", fetch_cnt1, 3);

    // Test 2: backpressure fills queue, then drains in order
    out_ready = 1'b0;
    do_reset();
    repeat (5) @(negedge clk);
    check("t2_imem_addr", imem_addr1, 32'h8);
    check("t2_fetch_cnt", fetch_cnt1, 2);
    check("t2_head_pc", out_pc1, 32'h0);
    out_ready = 1'b1;
    push_exp(32'h0, mem_word(32'h0));
    push_exp(32'h4, mem_word(32'h4));
    push_exp(32'h8, mem_word(32'h8));
    push_exp(32'hC, mem_word(32'hC));
    expect_out(4, 1'b0, cyc);
    check("t2_drain_cycles", cyc, 3);

    // Test 3: redirect with a full queue, misaligned target
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_pre_valid", out_valid1, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t3_flush_valid", out_valid1, 0);
    check("t3_imem_addr", imem_addr1, 32'h100);
    out_ready = 1'b1;
    sb.delete();
    push_exp(32'h100, mem_word(32'h100));
    expect_out(1, 1'b0, cyc);
    check("t3_latency", cyc, 1);

    // Test 4: EBREAK halts fetch, redirect resumes
    ebreak_en = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    do_reset();
    push_exp(32'h0, 32'h13);
    push_exp(32'h4, 32'h93);
    push_exp(32'h8, EBREAK_W);
    expect_out(3, 1'b0, cyc);
    repeat (3) @(negedge clk);
    check("t4_halted", halted1, 1);
    check("t4_imem_addr", imem_addr1, 32'hC);
    check("t4_fetch_cnt", fetch_cnt1, 3);
    check("t4_out_valid", out_valid1, 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t4_unhalted", halted1, 0);
    check("t4_redir_valid", out_valid1, 0);
    check("t4_redir_addr", imem_addr1, 32'h40);
    push_exp(32'h40, mem_word(32'h40));
    push_exp(32'h44, mem_word(32'h44));
    expect_out(2, 1'b0, cyc);
    ebreak_en = 1'b0;

    // Test 6: asynchronous reset mid-cycle with a full queue
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_pre_valid", out_valid1, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_out_valid", out_valid1, 0);
    check("t6_out_pc", out_pc1, 0);
    check("t6_halted", halted1, 0);
    check("t6_fetch_cnt", fetch_cnt1, 0);
    check("t6_imem_addr", imem_addr1, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Test 5: PC wrap-around on the high RESET_PC instance
    sb.delete();
    push_exp(32'hFFFF_FFF8, mem_word(32'hFFFF_FFF8));
    push_exp(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
    push_exp(32'h0000_0000, mem_word(32'h0000_0000));
    push_exp(32'h0000_0004, mem_word(32'h0000_0004));
    expect_out(4, 1'b1, cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
